// File: rtl/tlc_rr_timed.sv
// Timed round-robin traffic light controller: Moore FSM (GREEN/YELLOW/ALL_RED)
// with min/max green, fixed yellow and all-red clearance, and a latched next owner.
module tlc_rr_timed #(
  parameter int NUM_DIR    = 2,
  parameter int TW         = 8,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int RED_CYC    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_DIR-1:0]   T,
  output logic [2*NUM_DIR-1:0] L,
  output logic [1:0]           active_dir,
  output logic [1:0]           phase
);

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    ALL_RED = 2'b10
  } state_t;

  localparam logic [TW-1:0] MIN_T = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_T = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] RED_T = TW'(RED_CYC - 1);

  state_t        state, nxt_state;
  logic [TW-1:0] timer, nxt_timer;
  logic [1:0]    target, nxt_target, nxt_dir;
  logic [NUM_DIR-1:0] rot;
  logic          self_req, other_req;
  logic [1:0]    search;

  function automatic logic [2*NUM_DIR-1:0] lights(input state_t s, input logic [1:0] d);
    logic [2*NUM_DIR-1:0] l;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (s != ALL_RED && 2'(i) == d)
        l[2*i +: 2] = (s == GREEN) ? 2'b00 : 2'b01;
      else
        l[2*i +: 2] = 2'b10;
    end
    return l;
  endfunction

  // rot[k] is the request of direction (active_dir + k) mod NUM_DIR, so the
  // round-robin search walks rot upward; the descending loop keeps the first hit.
  always_comb begin : req_scan
    logic [2:0] sum;
    rot       = NUM_DIR'({T, T} >> active_dir);
    self_req  = rot[0];
    other_req = |rot[NUM_DIR-1:1];
    search    = active_dir;
    sum       = '0;
    for (int unsigned k = NUM_DIR - 1; k >= 1; k--) begin
      if (rot[k]) begin
        sum = {1'b0, active_dir} + 3'(k);
        if (sum >= 3'(NUM_DIR))
          sum = sum - 3'(NUM_DIR);
        search = 2'(sum);
      end
    end
  end

  always_comb begin : next_state
    nxt_state  = state;
    nxt_target = target;
    nxt_dir    = active_dir;
    case (state)
      GREEN: begin
        if (other_req && ((timer >= MIN_T && !self_req) || timer >= MAX_T)) begin
          nxt_state  = YELLOW;
          nxt_target = search;
        end
      end
      YELLOW: begin
        if (timer == YEL_T)
          nxt_state = ALL_RED;
      end
      ALL_RED: begin
        if (timer == RED_T) begin
          nxt_state = GREEN;
          nxt_dir   = target;
        end
      end
      default: nxt_state = GREEN;
    endcase
    if (nxt_state != state)
      nxt_timer = '0;
    else if (timer == '1)
      nxt_timer = timer;
    else
      nxt_timer = timer + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= GREEN;
      timer      <= '0;
      active_dir <= '0;
      target     <= '0;
      L          <= lights(GREEN, 2'b00);
    end else begin
      state      <= nxt_state;
      timer      <= nxt_timer;
      active_dir <= nxt_dir;
      target     <= nxt_target;
      L          <= lights(nxt_state, nxt_dir);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_tlc_rr_timed.sv
// Directed bench for tlc_rr_timed: a 2-direction and a 3-direction instance,
// with outputs sampled on the falling edge (cycle n = value seen before rising edge n).
module tb_tlc_rr_timed;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] t2;
  logic [2:0] t3;
  logic [3:0] l2;
  logic [5:0] l3;
  logic [1:0] dir2, dir3, ph2, ph3;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [3:0] G0  = 4'b1000;
  localparam logic [3:0] Y0  = 4'b1001;
  localparam logic [3:0] G1  = 4'b0010;
  localparam logic [3:0] Y1  = 4'b0110;
  localparam logic [3:0] AR2 = 4'b1010;
  localparam logic [5:0] G0_3 = 6'b101000;
  localparam logic [5:0] Y0_3 = 6'b101001;
  localparam logic [5:0] G2_3 = 6'b001010;
  localparam logic [5:0] Y2_3 = 6'b011010;
  localparam logic [5:0] AR3  = 6'b101010;

  tlc_rr_timed dut2 (
    .clk(clk), .reset_n(reset_n), .T(t2), .L(l2), .active_dir(dir2), .phase(ph2)
  );

  tlc_rr_timed #(.NUM_DIR(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .T(t3), .L(l3), .active_dir(dir3), .phase(ph3)
  );

  always #5 clk = ~clk;

  task automatic chk2(input string tag, input logic [3:0] el, input logic [1:0] eph,
                      input logic [1:0] ed);
    n_assert++;
    assert ({l2, ph2, dir2} === {el, eph, ed}) else begin
      n_fail++;
      $error("FAIL %s: observed L=%b phase=%b dir=%0d, expected L=%b phase=%b dir=%0d",
             tag, l2, ph2, dir2, el, eph, ed);
    end
  endtask

  task automatic chk3(input string tag, input logic [5:0] el, input logic [1:0] eph,
                      input logic [1:0] ed);
    n_assert++;
    assert ({l3, ph3, dir3} === {el, eph, ed}) else begin
      n_fail++;
      $error("FAIL %s: observed L=%b phase=%b dir=%0d, expected L=%b phase=%b dir=%0d",
             tag, l3, ph3, dir3, el, eph, ed);
    end
  endtask

  // Leaves the bench at the falling edge of cycle 0 with reset just released.
  task automatic do_reset(input logic [1:0] a, input logic [2:0] b);
    reset_n = 1'b0;
    t2 = a;
    t3 = b;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    t2 = '0;
    t3 = '0;
    @(negedge clk);

    // Idle: no traffic, direction 0 keeps green
    do_reset(2'b00, 3'b000);
    chk3("reset3", G0_3, 2'b00, 2'd0);
    for (int c = 0; c < 20; c++) begin
      chk2("idle", G0, 2'b00, 2'd0);
      @(negedge clk);
    end

    // Single request on dir1: min green then handover
    do_reset(2'b10, 3'b000);
    for (int c = 0; c < 13; c++) begin
      if (c < 4)       chk2("min_green", G0,  2'b00, 2'd0);
      else if (c < 6)  chk2("yellow0",   Y0,  2'b01, 2'd0);
      else if (c == 6) chk2("allred0",   AR2, 2'b10, 2'd0);
      else             chk2("green1",    G1,  2'b00, 2'd1);
      @(negedge clk);
    end

    // Both requesting: max green alternation with period 22
    do_reset(2'b11, 3'b000);
    for (int c = 0; c < 26; c++) begin
      int p;
      p = c % 22;
      if (p < 8)        chk2("max_g0", G0,  2'b00, 2'd0);
      else if (p < 10)  chk2("alt_y0", Y0,  2'b01, 2'd0);
      else if (p == 10) chk2("alt_r0", AR2, 2'b10, 2'd0);
      else if (p < 19)  chk2("max_g1", G1,  2'b00, 2'd1);
      else if (p < 21)  chk2("alt_y1", Y1,  2'b01, 2'd1);
      else              chk2("alt_r1", AR2, 2'b10, 2'd1);
      @(negedge clk);
    end

    // Three directions: skip dir1, then wrap from dir2 to dir0
    do_reset(2'b00, 3'b100);
    for (int c = 0; c < 16; c++) begin
      if (c < 4)        chk3("d3_g0",   G0_3, 2'b00, 2'd0);
      else if (c < 6)   chk3("d3_y0",   Y0_3, 2'b01, 2'd0);
      else if (c == 6)  chk3("d3_r0",   AR3,  2'b10, 2'd0);
      else if (c < 11)  chk3("d3_skip", G2_3, 2'b00, 2'd2);
      else if (c < 13)  chk3("d3_y2",   Y2_3, 2'b01, 2'd2);
      else if (c == 13) chk3("d3_r2",   AR3,  2'b10, 2'd2);
      else              chk3("d3_wrap", G0_3, 2'b00, 2'd0);
      if (c == 7) t3 = 3'b001;
      @(negedge clk);
    end

    // Reset asserted in yellow: outputs hold until the edge, then dir0 green
    do_reset(2'b10, 3'b000);
    repeat (4) @(negedge clk);
    chk2("mid_yellow", Y0, 2'b01, 2'd0);
    reset_n = 1'b0;
    #1;
    chk2("no_async", Y0, 2'b01, 2'd0);
    @(negedge clk);
    chk2("rst_yellow", G0, 2'b00, 2'd0);
    reset_n = 1'b1;
    t2 = 2'b00;

    // Request dropped in all-red: latched target still served, then holds
    do_reset(2'b10, 3'b000);
    repeat (6) @(negedge clk);
    chk2("drop_ar", AR2, 2'b10, 2'd0);
    t2 = 2'b00;
    @(negedge clk);
    chk2("drop_g1", G1, 2'b00, 2'd1);
    repeat (5) @(negedge clk);
    chk2("drop_hold", G1, 2'b00, 2'd1);

    // Long hold past timer saturation: a new request must still see timer >= MIN
    repeat (252) @(negedge clk);
    chk2("sat_hold", G1, 2'b00, 2'd1);
    t2 = 2'b01;
    @(negedge clk);
    chk2("sat_switch", Y1, 2'b01, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_rr_timed.md
TLC_RR_TIMED -- requirements
Module: tlc_rr_timed

Interface
REQ-001 SHALL have parameter NUM_DIR, default 2: number of approach directions, legal range 2..4.
REQ-002 SHALL have parameter TW, default 8: timer width in bits.
REQ-003 SHALL have parameter MIN_GREEN, default 4: minimum green duration in cycles.
REQ-004 SHALL have parameter MAX_GREEN, default 8: maximum green duration in cycles while another direction requests.
REQ-005 SHALL have parameter YELLOW_CYC, default 2: yellow duration in cycles.
REQ-006 SHALL have parameter RED_CYC, default 1: all-red clearance duration in cycles.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have port T, input, NUM_DIR bits: per-direction traffic sensor; T[i]=1 means traffic present.
REQ-010 SHALL have port L, output, 2*NUM_DIR bits: light for direction i is L[2i+1:2i], encoded 00 green, 01 yellow, 10 red; 11 never driven.
REQ-011 SHALL have port active_dir, output, 2 bits: index of the direction currently owning the green/yellow phase.
REQ-012 SHALL have port phase, output, 2 bits: 00 GREEN, 01 YELLOW, 10 ALL_RED.

Function
REQ-013 SHALL be a Moore machine with states GREEN, YELLOW, ALL_RED; L, active_dir and phase SHALL depend only on registered state.
REQ-014 SHALL keep a TW-bit timer that clears to 0 on every state change and otherwise increments each cycle, saturating at 2^TW-1.
REQ-015 In GREEN, "other request" SHALL mean T[j]=1 for any j other than active_dir.
REQ-016 GREEN->YELLOW SHALL occur when timer>=MIN_GREEN-1 and T[active_dir]=0 and another request is present, or when timer>=MAX_GREEN-1 and another request is present.
REQ-017 With no other request, GREEN SHALL hold indefinitely; timer saturation SHALL not cause a transition.
REQ-018 On GREEN->YELLOW, target SHALL be latched as the first j with T[j]=1, searching active_dir+1, active_dir+2, ... modulo NUM_DIR.
REQ-019 YELLOW->ALL_RED SHALL occur when timer=YELLOW_CYC-1; ALL_RED->GREEN SHALL occur when timer=RED_CYC-1, and active_dir SHALL load the latched target.
REQ-020 T changes during YELLOW or ALL_RED SHALL not alter the latched target or the timing.
REQ-021 L SHALL show green (GREEN) or yellow (YELLOW) on active_dir only; all other directions, and all directions in ALL_RED, SHALL show red.
REQ-022 Parameter rules SHALL hold: 1<=MIN_GREEN<=MAX_GREEN<2^TW, 1<=YELLOW_CYC<2^TW, 1<=RED_CYC<2^TW; active_dir upper bits beyond the NUM_DIR range SHALL be 0.

Reset
REQ-023 reset_n=0 sampled at a rising edge SHALL force state GREEN, active_dir=0, timer=0 and the latched target to 0, overriding any in-progress phase.
REQ-024 After reset, L SHALL show direction 0 green and all others red; phase=00.
REQ-025 No output SHALL change asynchronously to reset_n; reset_n asserted mid-YELLOW SHALL give direction 0 green on the next edge.

Verification
REQ-026 Bench SHALL use the defaults unless stated, with cycle 0 being the first edge after reset release.
REQ-027 Reset with T=00 held for 20 cycles -> L=4'b1000 (dir1 red, dir0 green) throughout, phase=00.
REQ-028 T=2'b10 from cycle 0 -> dir0 green cycles 0-3, yellow cycles 4-5, all-red cycle 6, dir1 green from cycle 7 (L=4'b0010).
REQ-029 T=2'b11 constant -> dir0 green for 8 cycles (MAX_GREEN), then 2 yellow, 1 red, then dir1 green, with continued alternation.
REQ-030 NUM_DIR=3, T=3'b100 -> after the yellow and red phases, active_dir=2, skipping dir1; later T=3'b001 -> wraps to dir0.
REQ-031 Reset asserted during YELLOW, and separately T dropped to 0 during ALL_RED -> reset case: dir0 green next edge; drop case: the latched target still gets green, then holds.
